// File: rtl/ir_hdng_fuse.sv
// IR heading fusion: box-car averages left/right IR per window, debounces wall-open
// flags and applies a per-window signed correction to the commanded heading.
// Optional IR_CLAMP_EN: saturate the correction to +/-MAX_ADJ and the output sum to the heading range.
module ir_hdng_fuse #(
  parameter int unsigned IR_W = 12,
  parameter int unsigned HDNG_W = 12,
  parameter int unsigned DTRM_W = 9,
  parameter int unsigned AVG_LOG2 = 2,
  parameter int unsigned OPN_DEB = 3,
  parameter logic [IR_W-1:0] NOM_IR = 12'h900,
  parameter logic [HDNG_W-1:0] MAX_ADJ = 12'h0C0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     smpl,
  input  logic [IR_W-1:0]          lft_IR,
  input  logic [IR_W-1:0]          rght_IR,
  input  logic                     lft_opn,
  input  logic                     rght_opn,
  input  logic signed [DTRM_W-1:0] IR_Dtrm,
  input  logic                     en_fusion,
  input  logic signed [HDNG_W-1:0] dsrd_hdng,
  output logic signed [HDNG_W-1:0] dsrd_hdng_adj,
  output logic                     adj_vld,
  output logic                     lft_opn_db,
  output logic                     rght_opn_db
);

  localparam int unsigned ACC_W = IR_W + AVG_LOG2;
  localparam int unsigned ERR_W = IR_W + 1;
  localparam int unsigned CW    = HDNG_W + 1;
  localparam int unsigned DEB_W = 3;

`ifdef IR_CLAMP_EN
  localparam bit CLAMP_EN = 1'b1;
`else
  localparam bit CLAMP_EN = 1'b0;
`endif

  localparam logic signed [ERR_W-1:0]  NOM_S = {1'b0, NOM_IR};
  localparam logic signed [CW-1:0]     MAX_P = {1'b0, MAX_ADJ};
  localparam logic signed [CW-1:0]     MAX_N = -MAX_P;
  localparam logic signed [HDNG_W-1:0] H_MAX = {1'b0, {(HDNG_W-1){1'b1}}};
  localparam logic signed [HDNG_W-1:0] H_MIN = {1'b1, {(HDNG_W-1){1'b0}}};

  typedef enum logic [1:0] {S_ACC = 2'd0, S_CALC = 2'd1, S_UPD = 2'd2} state_t;

  state_t state_q, state_d;
  logic   pending_q, pending_d;

  logic [ACC_W-1:0]    lft_acc, rght_acc, lft_sum, rght_sum;
  logic [AVG_LOG2-1:0] cnt;
  logic [IR_W-1:0]     lft_avg, rght_avg;
  logic                lft_flg, rght_flg;
  logic                win_done, win_go;

  logic [DEB_W-1:0] lft_dcnt, rght_dcnt, lft_dcnt_nx, rght_dcnt_nx;
  logic             lft_db_nx, rght_db_nx;

  logic signed [ERR_W-1:0]  lft_s, rght_s, err, err_d;
  logic signed [CW-1:0]     err_x, trm_x, corr_sum, corr_full, hsum;
  logic signed [HDNG_W-1:0] corr, corr_d, adj_d, hsat;

  // One debounce step: returns {next flag, next disagreement count}
  function automatic logic [DEB_W:0] deb_step(input logic raw, input logic db,
                                              input logic [DEB_W-1:0] dcnt);
    logic [DEB_W-1:0] inc;
    inc = dcnt + DEB_W'(1);
    if (raw == db)                  return {db, DEB_W'(0)};
    else if (inc == DEB_W'(OPN_DEB)) return {~db, DEB_W'(0)};
    else                            return {db, inc};
  endfunction

  always_comb begin
    lft_db_nx    = lft_opn_db;
    lft_dcnt_nx  = lft_dcnt;
    rght_db_nx   = rght_opn_db;
    rght_dcnt_nx = rght_dcnt;
    if (smpl) begin
      {lft_db_nx, lft_dcnt_nx}   = deb_step(lft_opn, lft_opn_db, lft_dcnt);
      {rght_db_nx, rght_dcnt_nx} = deb_step(rght_opn, rght_opn_db, rght_dcnt);
    end
  end

  // Debouncers run regardless of en_fusion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lft_opn_db  <= 1'b0;
      rght_opn_db <= 1'b0;
      lft_dcnt    <= '0;
      rght_dcnt   <= '0;
    end else begin
      lft_opn_db  <= lft_db_nx;
      rght_opn_db <= rght_db_nx;
      lft_dcnt    <= lft_dcnt_nx;
      rght_dcnt   <= rght_dcnt_nx;
    end
  end

  assign lft_sum  = lft_acc + ACC_W'(lft_IR);
  assign rght_sum = rght_acc + ACC_W'(rght_IR);
  assign win_done = smpl && (cnt == {AVG_LOG2{1'b1}});
  assign win_go   = win_done && en_fusion;

  // Window accumulation; the completing sample is folded into the latched average
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lft_acc  <= '0;
      rght_acc <= '0;
      cnt      <= '0;
      lft_avg  <= '0;
      rght_avg <= '0;
      lft_flg  <= 1'b0;
      rght_flg <= 1'b0;
    end else if (!en_fusion) begin
      lft_acc  <= '0;
      rght_acc <= '0;
      cnt      <= '0;
    end else if (smpl) begin
      if (win_done) begin
        lft_acc  <= '0;
        rght_acc <= '0;
        cnt      <= '0;
        lft_avg  <= IR_W'(lft_sum >> AVG_LOG2);
        rght_avg <= IR_W'(rght_sum >> AVG_LOG2);
        lft_flg  <= lft_db_nx;
        rght_flg <= rght_db_nx;
      end else begin
        lft_acc  <= lft_sum;
        rght_acc <= rght_sum;
        cnt      <= cnt + AVG_LOG2'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_ACC;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
    end
  end

  // A window finishing mid-pipeline is held one-deep and restarts CALC from UPD
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    if (!en_fusion) begin
      state_d   = S_ACC;
      pending_d = 1'b0;
    end else begin
      case (state_q)
        S_ACC: begin
          if (win_go || pending_q) begin
            state_d   = S_CALC;
            pending_d = 1'b0;
          end
        end
        S_CALC: begin
          state_d = S_UPD;
          if (win_go) pending_d = 1'b1;
        end
        S_UPD: begin
          if (win_go || pending_q) begin
            state_d   = S_CALC;
            pending_d = 1'b0;
          end else begin
            state_d = S_ACC;
          end
        end
        default: state_d = S_ACC;
      endcase
    end
  end

  // Wall-relative error from the latched window averages
  always_comb begin
    lft_s  = {1'b0, lft_avg};
    rght_s = {1'b0, rght_avg};
    case ({lft_flg, rght_flg})
      2'b11:   err_d = '0;
      2'b10:   err_d = NOM_S - rght_s;
      2'b01:   err_d = lft_s - NOM_S;
      default: err_d = (lft_s - rght_s) >>> 1;
    endcase
  end

  always_comb begin
    err_x     = CW'(err >>> 5);
    trm_x     = CW'(IR_Dtrm);
    corr_sum  = err_x + (trm_x <<< 2);
    corr_full = corr_sum >>> 1;
    corr_d    = HDNG_W'(corr_full);
    if (CLAMP_EN) begin
      if (corr_full > MAX_P)      corr_d = HDNG_W'(MAX_P);
      else if (corr_full < MAX_N) corr_d = HDNG_W'(MAX_N);
    end
  end

  // Heading sum: wraps by default, saturates to the signed range when clamped
  always_comb begin
    hsum = CW'(dsrd_hdng) + CW'(corr);
    hsat = HDNG_W'(hsum);
    if (hsum[CW-1] != hsum[CW-2]) hsat = hsum[CW-1] ? H_MIN : H_MAX;
    adj_d = CLAMP_EN ? hsat : (dsrd_hdng + corr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err           <= '0;
      corr          <= '0;
      adj_vld       <= 1'b0;
      dsrd_hdng_adj <= '0;
    end else begin
      if (state_q == S_CALC) err <= err_d;
      if (!en_fusion)             corr <= '0;
      else if (state_q == S_UPD)  corr <= corr_d;
      adj_vld       <= en_fusion && (state_q == S_UPD);
      dsrd_hdng_adj <= en_fusion ? adj_d : dsrd_hdng;
    end
  end

endmodule
